// File: rtl/axi2per_bridge.sv
// axi2per_bridge: AXI4 slave to 32-bit peripheral-bus master, one beat per peripheral access.
module axi2per_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int PER_ID_WIDTH   = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      axi_slave_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr,
  input  logic [7:0]                axi_slave_aw_len,
  input  logic [1:0]                axi_slave_aw_burst,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id,
  output logic                      axi_slave_aw_ready,
  input  logic                      axi_slave_w_valid,
  input  logic [31:0]               axi_slave_w_data,
  input  logic [3:0]                axi_slave_w_strb,
  input  logic                      axi_slave_w_last,
  output logic                      axi_slave_w_ready,
  output logic                      axi_slave_b_valid,
  output logic [1:0]                axi_slave_b_resp,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id,
  input  logic                      axi_slave_b_ready,
  input  logic                      axi_slave_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr,
  input  logic [7:0]                axi_slave_ar_len,
  input  logic [1:0]                axi_slave_ar_burst,
  input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id,
  output logic                      axi_slave_ar_ready,
  output logic                      axi_slave_r_valid,
  output logic [31:0]               axi_slave_r_data,
  output logic [1:0]                axi_slave_r_resp,
  output logic                      axi_slave_r_last,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id,
  input  logic                      axi_slave_r_ready,
  output logic                      per_master_req,
  output logic [AXI_ADDR_WIDTH-1:0] per_master_add,
  output logic                      per_master_we,
  output logic [31:0]               per_master_wdata,
  output logic [3:0]                per_master_be,
  output logic [PER_ID_WIDTH-1:0]   per_master_id,
  input  logic                      per_master_gnt,
  input  logic                      per_master_r_valid,
  input  logic                      per_master_r_opc,
  input  logic [31:0]               per_master_r_rdata,
  output logic                      busy_o
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP} state_t;
  state_t                    state;
  logic                      rr_wr;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [7:0]                len;
  logic [7:0]                cnt;
  logic [1:0]                burst;
  logic [AXI_ID_WIDTH-1:0]   id;
  logic                      err;
  logic                      ropc;
  logic [31:0]               rdata;
  logic [31:0]               wdata;
  logic [3:0]                strb;
  logic                      sel_rd;
  logic                      last;
  logic [AXI_ADDR_WIDTH-1:0] nxt_addr;
  logic                      unused;
  assign unused   = axi_slave_w_last;
  // rr_wr set means the next collision goes to the write channel
  assign sel_rd   = axi_slave_ar_valid && (!axi_slave_aw_valid || !rr_wr);
  assign last     = cnt == len;
  assign nxt_addr = burst == 2'b00 ? addr : addr + AXI_ADDR_WIDTH'(4);
  assign axi_slave_ar_ready = state == IDLE && sel_rd;
  assign axi_slave_aw_ready = state == IDLE && axi_slave_aw_valid && !sel_rd;
  assign axi_slave_w_ready  = state == WR_DATA;
  assign axi_slave_b_valid  = state == WR_RESP;
  assign axi_slave_b_resp   = {err, 1'b0};
  assign axi_slave_b_id     = id;
  assign axi_slave_r_valid  = state == RD_RESP;
  assign axi_slave_r_data   = rdata;
  assign axi_slave_r_resp   = {ropc, 1'b0};
  assign axi_slave_r_last   = state == RD_RESP && last;
  assign axi_slave_r_id     = id;
  assign per_master_req     = state == RD_REQ || state == WR_REQ;
  assign per_master_add     = addr;
  assign per_master_we      = state == WR_REQ;
  assign per_master_wdata   = wdata;
  assign per_master_be      = state == WR_REQ ? strb : state == RD_REQ ? 4'hF : 4'h0;
  assign per_master_id      = '0;
  assign busy_o             = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rr_wr <= 1'b0;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      burst <= '0;
      id    <= '0;
      err   <= 1'b0;
      ropc  <= 1'b0;
      rdata <= '0;
      wdata <= '0;
      strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (axi_slave_ar_valid && axi_slave_aw_valid) rr_wr <= !rr_wr;
          if (axi_slave_ar_ready) begin
            addr  <= axi_slave_ar_addr;
            len   <= axi_slave_ar_len;
            burst <= axi_slave_ar_burst;
            id    <= axi_slave_ar_id;
            cnt   <= '0;
            err   <= 1'b0;
            state <= RD_REQ;
          end else if (axi_slave_aw_ready) begin
            addr  <= axi_slave_aw_addr;
            len   <= axi_slave_aw_len;
            burst <= axi_slave_aw_burst;
            id    <= axi_slave_aw_id;
            cnt   <= '0;
            err   <= 1'b0;
            state <= WR_DATA;
          end
        end
        RD_REQ: if (per_master_gnt) state <= RD_WAIT;
        RD_WAIT: if (per_master_r_valid) begin
          rdata <= per_master_r_rdata;
          ropc  <= per_master_r_opc;
          state <= RD_RESP;
        end
        RD_RESP: if (axi_slave_r_ready) begin
          if (last) state <= IDLE;
          else begin
            addr  <= nxt_addr;
            cnt   <= cnt + 8'd1;
            state <= RD_REQ;
          end
        end
        WR_DATA: if (axi_slave_w_valid) begin
          wdata <= axi_slave_w_data;
          strb  <= axi_slave_w_strb;
          // an all-zero strobe beat needs no peripheral access
          if (axi_slave_w_strb != 4'h0) state <= WR_REQ;
          else if (last) state <= WR_RESP;
          else begin
            addr <= nxt_addr;
            cnt  <= cnt + 8'd1;
          end
        end
        WR_REQ: if (per_master_gnt) state <= WR_WAIT;
        WR_WAIT: if (per_master_r_valid) begin
          err <= err | per_master_r_opc;
          if (last) state <= WR_RESP;
          else begin
            addr  <= nxt_addr;
            cnt   <= cnt + 8'd1;
            state <= WR_DATA;
          end
        end
        WR_RESP: if (axi_slave_b_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi2per_bridge.sv
// tb_axi2per_bridge: directed bench with a reactive peripheral model and request log.
module tb_axi2per_bridge;
  logic        clk_i, rst_i;
  logic        axi_slave_aw_valid, axi_slave_aw_ready;
  logic [31:0] axi_slave_aw_addr;
  logic [7:0]  axi_slave_aw_len;
  logic [1:0]  axi_slave_aw_burst;
  logic [3:0]  axi_slave_aw_id;
  logic        axi_slave_w_valid, axi_slave_w_last, axi_slave_w_ready;
  logic [31:0] axi_slave_w_data;
  logic [3:0]  axi_slave_w_strb;
  logic        axi_slave_b_valid, axi_slave_b_ready;
  logic [1:0]  axi_slave_b_resp;
  logic [3:0]  axi_slave_b_id;
  logic        axi_slave_ar_valid, axi_slave_ar_ready;
  logic [31:0] axi_slave_ar_addr;
  logic [7:0]  axi_slave_ar_len;
  logic [1:0]  axi_slave_ar_burst;
  logic [3:0]  axi_slave_ar_id;
  logic        axi_slave_r_valid, axi_slave_r_last, axi_slave_r_ready;
  logic [31:0] axi_slave_r_data;
  logic [1:0]  axi_slave_r_resp;
  logic [3:0]  axi_slave_r_id;
  logic        per_master_req, per_master_we, per_master_gnt;
  logic [31:0] per_master_add, per_master_wdata;
  logic [3:0]  per_master_be;
  logic [4:0]  per_master_id;
  logic        per_master_r_valid, per_master_r_opc;
  logic [31:0] per_master_r_rdata;
  logic        busy_o;

  axi2per_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_slave_aw_valid(axi_slave_aw_valid), .axi_slave_aw_addr(axi_slave_aw_addr),
    .axi_slave_aw_len(axi_slave_aw_len), .axi_slave_aw_burst(axi_slave_aw_burst),
    .axi_slave_aw_id(axi_slave_aw_id), .axi_slave_aw_ready(axi_slave_aw_ready),
    .axi_slave_w_valid(axi_slave_w_valid), .axi_slave_w_data(axi_slave_w_data),
    .axi_slave_w_strb(axi_slave_w_strb), .axi_slave_w_last(axi_slave_w_last),
    .axi_slave_w_ready(axi_slave_w_ready),
    .axi_slave_b_valid(axi_slave_b_valid), .axi_slave_b_resp(axi_slave_b_resp),
    .axi_slave_b_id(axi_slave_b_id), .axi_slave_b_ready(axi_slave_b_ready),
    .axi_slave_ar_valid(axi_slave_ar_valid), .axi_slave_ar_addr(axi_slave_ar_addr),
    .axi_slave_ar_len(axi_slave_ar_len), .axi_slave_ar_burst(axi_slave_ar_burst),
    .axi_slave_ar_id(axi_slave_ar_id), .axi_slave_ar_ready(axi_slave_ar_ready),
    .axi_slave_r_valid(axi_slave_r_valid), .axi_slave_r_data(axi_slave_r_data),
    .axi_slave_r_resp(axi_slave_r_resp), .axi_slave_r_last(axi_slave_r_last),
    .axi_slave_r_id(axi_slave_r_id), .axi_slave_r_ready(axi_slave_r_ready),
    .per_master_req(per_master_req), .per_master_add(per_master_add),
    .per_master_we(per_master_we), .per_master_wdata(per_master_wdata),
    .per_master_be(per_master_be), .per_master_id(per_master_id),
    .per_master_gnt(per_master_gnt), .per_master_r_valid(per_master_r_valid),
    .per_master_r_opc(per_master_r_opc), .per_master_r_rdata(per_master_r_rdata),
    .busy_o(busy_o)
  );

  int          n_chk, n_fail;
  int          nreq, gnt_dly, wcnt, ridx;
  logic        pend, mute, stray;
  logic [31:0] rd_data [64];
  logic        opc_v   [64];
  logic [31:0] lg_add  [64];
  logic        lg_we   [64];
  logic [31:0] lg_wd   [64];
  logic [3:0]  lg_be   [64];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // peripheral: grants after gnt_dly waiting cycles, answers one cycle after the grant
  initial begin
    pend = 0; mute = 0; stray = 0; nreq = 0; gnt_dly = 0; wcnt = 0; ridx = 0;
    per_master_gnt = 0; per_master_r_valid = 0; per_master_r_opc = 0; per_master_r_rdata = 0;
    forever begin
      @(negedge clk_i);
      per_master_r_valid = 0;
      per_master_r_opc = 0;
      if (pend) begin
        if (!mute) begin
          per_master_r_valid = 1;
          per_master_r_rdata = rd_data[ridx];
          per_master_r_opc = opc_v[ridx];
        end
        pend = 0;
      end
      if (stray) begin
        per_master_r_valid = 1;
        per_master_r_rdata = 32'h0BAD_0BAD;
        stray = 0;
      end
      per_master_gnt = 0;
      if (per_master_req) begin
        if (wcnt >= gnt_dly) begin
          per_master_gnt = 1;
          if (nreq < 64) begin
            lg_add[nreq] = per_master_add;
            lg_we[nreq] = per_master_we;
            lg_wd[nreq] = per_master_wdata;
            lg_be[nreq] = per_master_be;
          end
          ridx = nreq;
          nreq++;
          pend = 1;
          wcnt = 0;
        end else wcnt++;
      end
    end
  end

  task automatic clear_model();
    nreq = 0;
    for (int k = 0; k < 64; k++) begin
      rd_data[k] = 32'hA000_0000 + k;
      opc_v[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_i = 1;
    axi_slave_ar_valid = 0; axi_slave_aw_valid = 0; axi_slave_w_valid = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
  endtask

  task automatic hs_ar();
    for (int k = 0; k < 50; k++) begin
      if (axi_slave_ar_ready) begin
        @(posedge clk_i);
        #1 axi_slave_ar_valid = 0;
        return;
      end
      @(negedge clk_i); #1;
    end
    check("ar_timeout", 0, 1);
    axi_slave_ar_valid = 0;
  endtask

  task automatic hs_aw();
    for (int k = 0; k < 50; k++) begin
      if (axi_slave_aw_ready) begin
        @(posedge clk_i);
        #1 axi_slave_aw_valid = 0;
        return;
      end
      @(negedge clk_i); #1;
    end
    check("aw_timeout", 0, 1);
    axi_slave_aw_valid = 0;
  endtask

  task automatic ar_go(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] i);
    @(negedge clk_i);
    axi_slave_ar_valid = 1; axi_slave_ar_addr = a; axi_slave_ar_len = l;
    axi_slave_ar_burst = b; axi_slave_ar_id = i;
    #1 hs_ar();
  endtask

  task automatic aw_go(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [3:0] i);
    @(negedge clk_i);
    axi_slave_aw_valid = 1; axi_slave_aw_addr = a; axi_slave_aw_len = l;
    axi_slave_aw_burst = b; axi_slave_aw_id = i;
    #1 hs_aw();
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    axi_slave_w_valid = 1; axi_slave_w_data = d; axi_slave_w_strb = s;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (axi_slave_w_ready) begin
        @(posedge clk_i);
        #1 axi_slave_w_valid = 0;
        return;
      end
      @(negedge clk_i); #1;
    end
    check("w_timeout", 0, 1);
    axi_slave_w_valid = 0;
  endtask

  task automatic rd_beat(output logic [31:0] d, output logic [1:0] rs, output logic l,
                         output logic [3:0] i, output int cyc);
    cyc = 0;
    axi_slave_r_ready = 1;
    while (!axi_slave_r_valid && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!axi_slave_r_valid) check("r_timeout", 0, 1);
    d = axi_slave_r_data; rs = axi_slave_r_resp; l = axi_slave_r_last; i = axi_slave_r_id;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_b(output logic [1:0] rs, output logic [3:0] i);
    int cyc = 0;
    axi_slave_b_ready = 1;
    while (!axi_slave_b_valid && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!axi_slave_b_valid) check("b_timeout", 0, 1);
    check("busy_at_b", busy_o, 1);
    rs = axi_slave_b_resp; i = axi_slave_b_id;
    @(posedge clk_i); #1;
  endtask

  task automatic collide(input logic exp_rd);
    logic [31:0] d; logic [1:0] rs; logic l; logic [3:0] i; int cyc;
    @(negedge clk_i);
    axi_slave_ar_valid = 1; axi_slave_ar_addr = 32'h600; axi_slave_ar_len = 0;
    axi_slave_ar_burst = 2'b01; axi_slave_ar_id = 4'd1;
    axi_slave_aw_valid = 1; axi_slave_aw_addr = 32'h700; axi_slave_aw_len = 0;
    axi_slave_aw_burst = 2'b01; axi_slave_aw_id = 4'd2;
    #1;
    check("arb_ar_ready", axi_slave_ar_ready, exp_rd);
    check("arb_aw_ready", axi_slave_aw_ready, !exp_rd);
    if (exp_rd) begin
      hs_ar();
      rd_beat(d, rs, l, i, cyc);
      check("arb_r_id", i, 4'd1);
      hs_aw();
      w_send(32'h7777_0000, 4'hF);
      wait_b(rs, i);
      check("arb_b_id", i, 4'd2);
    end else begin
      hs_aw();
      w_send(32'h7777_0000, 4'hF);
      wait_b(rs, i);
      check("arb_b_id", i, 4'd2);
      hs_ar();
      rd_beat(d, rs, l, i, cyc);
      check("arb_r_id", i, 4'd1);
    end
  endtask

  initial begin
    logic [31:0] d, d0;
    logic [1:0]  rs;
    logic        l;
    logic [3:0]  i;
    int          cyc;
    n_chk = 0; n_fail = 0;
    axi_slave_ar_addr = 0; axi_slave_ar_len = 0; axi_slave_ar_burst = 0; axi_slave_ar_id = 0;
    axi_slave_aw_addr = 0; axi_slave_aw_len = 0; axi_slave_aw_burst = 0; axi_slave_aw_id = 0;
    axi_slave_w_data = 0; axi_slave_w_strb = 0; axi_slave_w_last = 0;
    axi_slave_r_ready = 1; axi_slave_b_ready = 1;
    clear_model();
    do_reset();
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_req", per_master_req, 0);
    check("rst_valids", {axi_slave_r_valid, axi_slave_b_valid, axi_slave_w_ready,
                         axi_slave_ar_ready, axi_slave_aw_ready}, 0);
    check("rst_data", {axi_slave_r_data, per_master_add}, 0);

    // single read, 3-cycle latency
    clear_model();
    rd_data[0] = 32'hDEAD_BEEF;
    ar_go(32'h1000_0010, 0, 2'b01, 4'd3);
    rd_beat(d, rs, l, i, cyc);
    check("rd1_latency", cyc, 3);
    check("rd1_data", d, 32'hDEAD_BEEF);
    check("rd1_resp", rs, 2'b00);
    check("rd1_last", l, 1);
    check("rd1_id", i, 4'd3);
    check("rd1_add", lg_add[0], 32'h1000_0010);
    check("rd1_we_be", {lg_we[0], lg_be[0]}, 5'h0F);
    @(negedge clk_i);
    check("rd1_idle", busy_o, 0);

    // INCR write with delayed grants
    clear_model();
    gnt_dly = 2;
    aw_go(32'h100, 3, 2'b01, 4'd6);
    for (int k = 0; k < 4; k++) w_send(32'h1111_0000 + k, 4'hF);
    wait_b(rs, i);
    check("wr_b_resp", rs, 2'b00);
    check("wr_b_id", i, 4'd6);
    @(negedge clk_i);
    check("wr_busy_drop", busy_o, 0);
    check("wr_nreq", nreq, 4);
    for (int k = 0; k < 4; k++) begin
      check("wr_add", lg_add[k], 32'h100 + 4 * k);
      check("wr_we_be_wd", {lg_we[k], lg_be[k], lg_wd[k]}, {1'b1, 4'hF, 32'h1111_0000 + k});
    end
    gnt_dly = 0;

    // sticky error and zero-strobe beat
    clear_model();
    opc_v[0] = 1;
    aw_go(32'h200, 1, 2'b01, 4'd5);
    w_send(32'hAAAA_AAAA, 4'hF);
    w_send(32'hBBBB_BBBB, 4'h0);
    wait_b(rs, i);
    check("err_b_resp", rs, 2'b10);
    check("err_b_id", i, 4'd5);
    check("err_nreq", nreq, 1);

    // read error only on the affected beat
    clear_model();
    opc_v[0] = 1;
    ar_go(32'h300, 1, 2'b01, 4'd7);
    rd_beat(d, rs, l, i, cyc);
    check("rerr_b0", {rs, l}, {2'b10, 1'b0});
    rd_beat(d, rs, l, i, cyc);
    check("rerr_b1", {rs, l}, {2'b00, 1'b1});
    check("rerr_add1", lg_add[1], 32'h304);

    // round-robin arbitration from reset
    do_reset();
    clear_model();
    collide(1);
    collide(0);
    collide(1);

    // FIXED burst with R backpressure on beat 1
    clear_model();
    ar_go(32'h20, 3, 2'b00, 4'd9);
    rd_beat(d, rs, l, i, cyc);
    check("fx_b0", d, 32'hA000_0000);
    axi_slave_r_ready = 0;
    cyc = 0;
    while (!axi_slave_r_valid && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    d0 = axi_slave_r_data;
    check("fx_b1", d0, 32'hA000_0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("fx_stall", {axi_slave_r_valid, per_master_req, axi_slave_r_data}, {1'b1, 1'b0, d0});
    end
    rd_beat(d, rs, l, i, cyc);
    rd_beat(d, rs, l, i, cyc);
    check("fx_b2", d, 32'hA000_0002);
    rd_beat(d, rs, l, i, cyc);
    check("fx_b3", {d, l, i}, {32'hA000_0003, 1'b1, 4'd9});
    check("fx_nreq", nreq, 4);
    for (int k = 0; k < 4; k++) check("fx_add", lg_add[k], 32'h20);

    // reset while waiting on beat 1 of a 4-beat write
    clear_model();
    aw_go(32'h400, 3, 2'b01, 4'd4);
    w_send(32'h4444_0000, 4'hF);
    w_send(32'h4444_0001, 4'hF);
    mute = 1;
    cyc = 0;
    while (nreq < 2 && cyc < 50) begin
      @(negedge clk_i); #1;
      cyc++;
    end
    check("mid_nreq", nreq, 2);
    @(negedge clk_i); #1;
    check("mid_busy", {busy_o, per_master_req}, 2'b10);
    rst_i = 1;
    @(posedge clk_i); #1 rst_i = 0;
    @(negedge clk_i); #1;
    check("mid_rst", {busy_o, per_master_req, axi_slave_r_valid, axi_slave_b_valid,
                      axi_slave_w_ready}, 0);
    stray = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); #1;
      check("stray_ign", {busy_o, axi_slave_r_valid, axi_slave_b_valid}, 0);
    end
    mute = 0;
    clear_model();
    ar_go(32'h500, 0, 2'b01, 4'd2);
    rd_beat(d, rs, l, i, cyc);
    check("post_rd", {d, rs, l, i}, {32'hA000_0000, 2'b00, 1'b1, 4'd2});
    check("post_add", lg_add[0], 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
